// File: rtl/otter_fetch_unit.sv
// OTTER instruction-fetch stage: PC generation, credit-limited imem handshake and an in-order
// {pc, instr} FIFO feeding the IF/ID register, with redirect flush and stale-response dropping.
module otter_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int unsigned DEPTH    = 4
) (
   input  logic        CLK,
   input  logic        RST_N,
   input  logic        redirect_E,
   input  logic [31:0] redirect_pc_E,
   input  logic        stall_D,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_gnt,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   output logic        valid_F,
   output logic [31:0] Instr_F,
   output logic [31:0] PC_F,
   output logic [31:0] PC_plus4_F
);

   localparam int unsigned CW = $clog2(DEPTH + 1);
   localparam int unsigned PW = $clog2(DEPTH);
   localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);
   localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
   localparam logic [31:0] NOP = 32'h0000_0013;

   logic [31:0]   fetch_pc_q, fetch_pc_d;
   logic [31:0]   resp_pc_q, resp_pc_d;
   logic [CW-1:0] inflight_q, inflight_d;
   logic [CW-1:0] drop_q, drop_d;
   logic [CW-1:0] count_q, count_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;

   logic [31:0]   pc_mem    [DEPTH];
   logic [31:0]   instr_mem [DEPTH];

   logic [CW:0]   occupancy;
   logic [31:0]   target_pc;
   logic          grant;
   logic          rsp;
   logic          push;
   logic          pop;
   logic          unused_bits;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == LAST_PTR) ? '0 : p + PW'(1);
   endfunction

   assign unused_bits = ^redirect_pc_E[1:0];
   assign target_pc   = {redirect_pc_E[31:2], 2'b00};

   // Credit covers buffered plus in-flight fetches, so a returning response always has a slot.
   assign occupancy = {1'b0, count_q} + {1'b0, inflight_q};
   assign imem_req  = RST_N && !redirect_E && (occupancy < DEPTH_W);
   assign imem_addr = fetch_pc_q;

   assign valid_F    = (count_q != '0) && !redirect_E;
   assign Instr_F    = valid_F ? instr_mem[rd_ptr_q] : NOP;
   assign PC_F       = valid_F ? pc_mem[rd_ptr_q] : 32'h0;
   assign PC_plus4_F = valid_F ? pc_mem[rd_ptr_q] + 32'd4 : 32'h0;

   always_comb begin
      grant      = imem_req && imem_gnt;
      // A response with nothing outstanding is a protocol error and is ignored.
      rsp        = imem_rvalid && (inflight_q != '0);
      push       = rsp && (drop_q == '0) && !redirect_E;
      pop        = valid_F && !stall_D;
      inflight_d = inflight_q + CW'(grant) - CW'(rsp);

      fetch_pc_d = fetch_pc_q;
      resp_pc_d  = resp_pc_q;
      drop_d     = drop_q;
      count_d    = count_q;
      rd_ptr_d   = rd_ptr_q;
      wr_ptr_d   = wr_ptr_q;

      if (redirect_E) begin
         // Everything still outstanding after this edge belongs to the old path.
         fetch_pc_d = target_pc;
         resp_pc_d  = target_pc;
         drop_d     = inflight_d;
         count_d    = '0;
         rd_ptr_d   = '0;
         wr_ptr_d   = '0;
      end else begin
         if (grant) begin
            fetch_pc_d = fetch_pc_q + 32'd4;
         end
         if (rsp && (drop_q != '0)) begin
            drop_d = drop_q - CW'(1);
         end
         if (push) begin
            resp_pc_d = resp_pc_q + 32'd4;
            wr_ptr_d  = ptr_inc(wr_ptr_q);
         end
         if (pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
         end
         count_d = count_q + CW'(push) - CW'(pop);
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         fetch_pc_q <= RESET_PC;
         resp_pc_q  <= RESET_PC;
         inflight_q <= '0;
         drop_q     <= '0;
         count_q    <= '0;
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
      end else begin
         fetch_pc_q <= fetch_pc_d;
         resp_pc_q  <= resp_pc_d;
         inflight_q <= inflight_d;
         drop_q     <= drop_d;
         count_q    <= count_d;
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
      end
   end

   always_ff @(posedge CLK) begin
      if (push) begin
         pc_mem[wr_ptr_q]    <= resp_pc_q;
         instr_mem[wr_ptr_q] <= imem_rdata;
      end
   end

endmodule
